// File: rtl/md_pkg.sv
// Shared definitions for the iterative RV64 M-extension unit.
// Holds the funct3 encodings, the controller state enum, the XLEN/WLEN
// widths and the helper that sign-extends a 32-bit *W result to XLEN.
package md_pkg;

  localparam int XLEN = 64;
  localparam int WLEN = 32;

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} md_state_e;

  function automatic logic [XLEN-1:0] sext_w(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration of the shared multiply/divide datapath.
// Ports:
//   is_div  - 1: restoring shift-subtract step, 0: shift-add step
//   acc     - {high half, low half} working register
//   operand - multiplicand (multiply) or divisor (divide) magnitude
//   acc_nxt - accumulator after this iteration
// Multiply: low half holds the remaining multiplier bits (LSB first), the
// high half collects the partial product; the whole pair shifts right.
// Divide: low half holds the dividend (MSB first) and fills with quotient
// bits; the high half is the partial remainder; the pair shifts left.
module md_step #(
  parameter int DATA_W = 64
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [DATA_W-1:0]     operand,
  output logic [2*DATA_W-1:0]   acc_nxt
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, operand} : '0);
    // Partial remainder shifted left with the next dividend bit brought in;
    // one extra bit keeps the trial subtraction exact for 64-bit divisors.
    rem_sh = acc[2*DATA_W-1:DATA_W-1];
    diff   = rem_sh - {1'b0, operand};
    if (is_div) begin
      if (!diff[DATA_W]) acc_nxt = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else               acc_nxt = {rem_sh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_ctrl.sv
// Iterative RV64 M-extension execute unit (MUL*/DIV*/REM* and *W forms).
// Ports:
//   i_clk, i_arst            - clock, synchronous active-high reset
//   i_start                  - execute stage holds an M instruction
//   i_func3, i_word          - operation select and *W variant
//   i_src_1, i_src_2         - forwarded operands (latched on acceptance)
//   i_flush                  - drop the operation in flight
//   i_stall_mem              - hold the finished result in DONE
//   o_stall                  - freeze fetch/decode/execute
//   o_done, o_result         - result valid / sign-extended result
// Signed operands are turned into magnitudes on acceptance; the iteration
// runs unsigned and the recorded sign is applied once in FIX.
module mul_div_ctrl
  import md_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_arst,
  input  logic            i_start,
  input  logic [2:0]      i_func3,
  input  logic            i_word,
  input  logic [XLEN-1:0] i_src_1,
  input  logic [XLEN-1:0] i_src_2,
  input  logic            i_flush,
  input  logic            i_stall_mem,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  md_state_e         state, state_nxt;
  logic [6:0]        cnt;
  logic [2*XLEN-1:0] acc, acc_step;
  logic [XLEN-1:0]   opb, result;
  logic [2:0]        func3_q;
  logic              word_q, res_neg;

  logic              is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic              div_zero, div_ovf, special, res_neg_d;
  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_neg, spec_raw, spec_res;

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, mul_sel, div_sel, fix_raw, fix_res;

  // Acceptance decode: operand extension, magnitudes, sign, special cases
  always_comb begin
    is_div  = i_func3[2];
    sgn_a   = (i_func3 == MULH) || (i_func3 == MULHSU) ||
              (i_func3 == DIV)  || (i_func3 == REM);
    sgn_b   = (i_func3 == MULH) || (i_func3 == DIV) || (i_func3 == REM);
    a_ext   = i_word ? (sgn_a ? sext_w(i_src_1[WLEN-1:0]) : {32'd0, i_src_1[WLEN-1:0]})
                     : i_src_1;
    b_ext   = i_word ? (sgn_b ? sext_w(i_src_2[WLEN-1:0]) : {32'd0, i_src_2[WLEN-1:0]})
                     : i_src_2;
    a_neg   = sgn_a & a_ext[XLEN-1];
    b_neg   = sgn_b & b_ext[XLEN-1];
    a_mag   = a_neg ? -a_ext : a_ext;
    b_mag   = b_neg ? -b_ext : b_ext;
    // Remainder follows the dividend; everything else is the product of signs.
    res_neg_d = (is_div && i_func3[1]) ? a_neg : (a_neg ^ b_neg);

    min_neg  = i_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero = is_div && (b_ext == '0);
    div_ovf  = is_div && !i_func3[0] && (a_ext == min_neg) && (b_ext == '1);
    special  = div_zero || div_ovf;

    spec_raw = '0;
    if (div_zero)     spec_raw = i_func3[1] ? a_ext : '1;
    else if (div_ovf) spec_raw = i_func3[1] ? '0 : a_ext;
    spec_res = i_word ? sext_w(spec_raw[WLEN-1:0]) : spec_raw;
  end

  md_step #(.DATA_W(XLEN)) u_step (
    .is_div  (func3_q[2]),
    .acc     (acc),
    .operand (opb),
    .acc_nxt (acc_step)
  );

  // Final selection: a *W multiply ran only 32 steps, so its 64-bit
  // product still sits 32 bits up in the accumulator.
  always_comb begin
    prod    = word_q ? {64'd0, acc[95:32]} : acc;
    prod_s  = res_neg ? -prod : prod;
    quo_s   = res_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s   = res_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    mul_sel = (func3_q == MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    div_sel = func3_q[1] ? rem_s : quo_s;
    fix_raw = func3_q[2] ? div_sel : mul_sel;
    fix_res = word_q ? sext_w(fix_raw[WLEN-1:0]) : fix_raw;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start && !i_flush) state_nxt = special ? DONE : CALC;
      CALC:    if (cnt == 7'd1) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (!i_stall_mem) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      func3_q <= '0;
      word_q  <= 1'b0;
      res_neg <= 1'b0;
      result  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_start && !i_flush) begin
          func3_q <= i_func3;
          word_q  <= i_word;
          res_neg <= res_neg_d;
          if (special) begin
            result <= spec_res;
          end else begin
            cnt <= i_word ? 7'd32 : 7'd64;
            if (is_div) begin
              // *W dividends are pre-shifted so their MSB is consumed first.
              acc <= {64'd0, (i_word ? {a_mag[WLEN-1:0], 32'd0} : a_mag)};
              opb <= b_mag;
            end else begin
              acc <= {64'd0, b_mag};
              opb <= a_mag;
            end
          end
        end
        CALC: if (!i_flush) begin
          acc <= acc_step;
          cnt <= cnt - 7'd1;
        end
        FIX: if (!i_flush) result <= fix_res;
        default: ;
      endcase
    end
  end

  assign o_done   = (state == DONE);
  assign o_stall  = i_start & ~o_done;
  assign o_result = result;

endmodule
